// File: rtl/instr_fetch_queue_if.sv
// Fetch-queue bundle: instruction-memory request/response channel, branch
// redirect from decode, and the valid/ready instruction stream into decode.
// The master modport is the fetch queue; the slave modport is its environment
// (memory plus decode).
interface instr_fetch_queue_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        out_valid;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic        out_ready;

  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc,
    input  imem_ack, imem_rvalid, imem_rdata, redirect, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc,
    output imem_ack, imem_rvalid, imem_rdata, redirect, redirect_pc, out_ready
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue for the 16-bit CPU front end.
// Keeps at most one instruction-memory request in flight. Each returned word
// is buffered with its PC in a DEPTH-entry FIFO that feeds decode in order.
// A redirect flushes the FIFO and restarts fetch at redirect_pc. A response
// that belongs to the flushed stream is dropped in the DISCARD state.
// Optional feature macro: FQ_BYPASS_EN. When it is defined, a response that
// arrives while the FIFO is empty is shown to decode in the same cycle. When
// decode takes it in that cycle, the word is not written into the FIFO.
module instr_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic               clock,
  input  logic               reset_n,
  instr_fetch_queue_if.master bus
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        fetchPc_q, fetchPc_d;
  logic [15:0]        reqPc_q, reqPc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
  logic [15:0]        instrMem_q [DEPTH];
  logic [15:0]        pcMem_q    [DEPTH];

  logic               reqOut;
  logic               rspAccept;
  logic               bypassHit;
  logic               queueValid;
  logic               push;
  logic               pop;
  logic               outValid;
  logic [15:0]        outInstr;
  logic [15:0]        outPc;

  // Fetch control: picks the next state, issues requests and moves the fetch PC.
  // A redirect always wins over the normal next PC.
  always_comb begin
    state_d   = state_q;
    fetchPc_d = fetchPc_q;
    reqPc_d   = reqPc_q;
    reqOut    = 1'b0;
    rspAccept = 1'b0;
    unique case (state_q)
      FETCH: begin
        reqOut = (count_q < FULL_COUNT) && !bus.redirect;
        if (reqOut && bus.imem_ack) begin
          state_d   = WAIT;
          reqPc_d   = fetchPc_q;
          fetchPc_d = fetchPc_q + 16'd1;
        end
      end
      WAIT: begin
        if (bus.imem_rvalid) begin
          state_d   = FETCH;
          rspAccept = !bus.redirect;
        end else if (bus.redirect) begin
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        // A stale response that arrives during a second redirect still ends the
        // outstanding request. Without this, the FSM would wait forever.
        if (bus.imem_rvalid) begin
          state_d = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
    if (bus.redirect) begin
      fetchPc_d = bus.redirect_pc;
    end
  end

  // Queue bookkeeping and head selection. The optional bypass forwards a word
  // that arrives into an empty queue directly to decode.
  always_comb begin
    queueValid = (count_q != '0);
    bypassHit  = 1'b0;
`ifdef FQ_BYPASS_EN
    bypassHit  = rspAccept && (count_q == '0);
`endif
    pop  = queueValid && bus.out_ready && !bus.redirect;
    push = rspAccept && !(bypassHit && bus.out_ready);

    outValid = queueValid;
    outInstr = queueValid ? instrMem_q[rdPtr_q] : 16'h0000;
    outPc    = queueValid ? pcMem_q[rdPtr_q]    : 16'h0000;
    if (bypassHit) begin
      outValid = 1'b1;
      outInstr = bus.imem_rdata;
      outPc    = reqPc_q;
    end

    if (bus.redirect) begin
      count_d = '0;
      rdPtr_d = '0;
      wrPtr_d = '0;
    end else begin
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      rdPtr_d = rdPtr_q + PTR_W'(pop);
      wrPtr_d = wrPtr_q + PTR_W'(push);
    end
  end

  // Control state, fetch PC, occupancy and pointers. All of these are cleared
  // asynchronously so the outputs go quiet as soon as reset is asserted.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= FETCH;
      fetchPc_q <= RESET_PC;
      reqPc_q   <= RESET_PC;
      count_q   <= '0;
      rdPtr_q   <= '0;
      wrPtr_q   <= '0;
    end else begin
      state_q   <= state_d;
      fetchPc_q <= fetchPc_d;
      reqPc_q   <= reqPc_d;
      count_q   <= count_d;
      rdPtr_q   <= rdPtr_d;
      wrPtr_q   <= wrPtr_d;
    end
  end

  // FIFO payload storage. It has no reset because a slot is only read after it
  // has been written.
  always_ff @(posedge clock) begin
    if (push) begin
      instrMem_q[wrPtr_q] <= bus.imem_rdata;
      pcMem_q[wrPtr_q]    <= reqPc_q;
    end
  end

  assign bus.imem_req  = reqOut && reset_n;
  assign bus.imem_addr = fetchPc_q;
  assign bus.out_valid = outValid;
  assign bus.out_instr = outInstr;
  assign bus.out_pc    = outPc;

endmodule
